// File: rtl/arb_seq_checker.sv
// rtl/arb_seq_checker.sv - code-sequence lock checker (0,1,2,3,6,5,7 repeating)
// Optional error counter built only when ARB_SEQ_ERRCNT_EN is defined.
module arb_seq_checker #(
  parameter int LOCK_THRESH = 3,
  parameter int MISS_LIMIT  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       out_valid,
  output logic [2:0] out_index,
  output logic       locked,
  output logic       seq_err,
  output logic       code_illegal,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam logic [2:0] LT = 3'(LOCK_THRESH);
  localparam logic [2:0] ML = 3'(MISS_LIMIT);

  state_t     r_state;
  logic [2:0] r_match;
  logic [2:0] r_miss;
  logic [2:0] r_exp;
  logic       r_out_valid;
  logic [2:0] r_out_index;
  logic       r_locked;
  logic       r_seq_err;
  logic       r_code_illegal;

  logic [2:0] w_idx;
  logic [2:0] w_seed;
  logic [2:0] w_exp_inc;
  logic       w_illegal;
  logic       w_hit;
  logic       w_err;

  always_comb begin
    w_idx = 3'd0;
    case (in_code)
      3'd0: w_idx = 3'd0;
      3'd1: w_idx = 3'd1;
      3'd2: w_idx = 3'd2;
      3'd3: w_idx = 3'd3;
      3'd4: w_idx = 3'd0;
      3'd5: w_idx = 3'd5;
      3'd6: w_idx = 3'd4;
      3'd7: w_idx = 3'd6;
      default: w_idx = 3'd0;
    endcase
  end

  assign w_illegal = (in_code == 3'd4);
  assign w_seed    = (w_idx == 3'd6) ? 3'd0 : w_idx + 3'd1;
  assign w_exp_inc = (r_exp == 3'd6) ? 3'd0 : r_exp + 3'd1;
  assign w_hit     = !w_illegal && (w_idx == r_exp);
  assign w_err     = in_valid && (r_state == LOCKED) && !w_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= SEARCH;
      r_match        <= 3'd0;
      r_miss         <= 3'd0;
      r_exp          <= 3'd0;
      r_out_valid    <= 1'b0;
      r_out_index    <= 3'd0;
      r_locked       <= 1'b0;
      r_seq_err      <= 1'b0;
      r_code_illegal <= 1'b0;
    end else begin
      r_out_valid    <= in_valid;
      r_seq_err      <= w_err;
      r_code_illegal <= in_valid && w_illegal;
      if (in_valid) begin
        r_out_index <= w_idx;
        case (r_state)
          SEARCH: begin
            if (!w_illegal) begin
              r_exp   <= w_seed;
              r_match <= 3'd1;
              r_state <= VERIFY;
            end
          end
          VERIFY: begin
            if (w_illegal) begin
              r_match <= 3'd0;
              r_state <= SEARCH;
            end else if (w_hit) begin
              r_match <= r_match + 3'd1;
              r_exp   <= w_exp_inc;
              if (r_match + 3'd1 == LT) begin
                r_miss   <= 3'd0;
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_exp   <= w_seed;
              r_match <= 3'd1;
            end
          end
          LOCKED: begin
            // Flywheel: expected position advances whether or not the code matched
            r_exp <= w_exp_inc;
            if (w_hit) begin
              r_miss <= 3'd0;
            end else if (r_miss + 3'd1 == ML) begin
              r_miss   <= 3'd0;
              r_match  <= 3'd0;
              r_state  <= SEARCH;
              r_locked <= 1'b0;
            end else begin
              r_miss <= r_miss + 3'd1;
            end
          end
          default: begin
            r_state  <= SEARCH;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef ARB_SEQ_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err_count <= 8'd0;
    end else if (w_err && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'd0;
`endif

  assign out_valid    = r_out_valid;
  assign out_index    = r_out_index;
  assign locked       = r_locked;
  assign seq_err      = r_seq_err;
  assign code_illegal = r_code_illegal;

endmodule
